// File: rtl/ifetch_axi_master_pkg.sv
// Shared definitions for the instruction-fetch AXI read master:
// FSM states, AXI encodings and the 4 KB page boundary test.
package ifetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Word index pc[11:2] of the last word in a 4 KB page; a 2-beat burst
  // starting there would cross the page, so only one beat is requested.
  localparam logic [9:0] PAGE_LAST_WORD = 10'h3FF;

  function automatic logic [7:0] burst_len(input logic [9:0] word_idx);
    return (word_idx == PAGE_LAST_WORD) ? 8'd0 : 8'd1;
  endfunction

endpackage

// File: rtl/ifetch_axi_master_if.sv
// AXI read-address and read-data channels used by the fetch master.
interface ifetch_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ifetch_axi_master.sv
// Fetches a two-instruction bundle over AXI per PC and hands it to decode;
// redirects (flush) drop the bundle, draining any burst already issued.
module ifetch_axi_master
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              flush,
  ifetch_axi_master_if.master axi,
  output logic [DATA_W-1:0] inst0,
  output logic [DATA_W-1:0] inst1,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst1_vld,
  output logic              inst_fault,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              pc_adv
);

  fetch_state_e      state, nxt;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic              flush_pend;
  logic              beat_idx;
  logic              rready;
  logic              r_beat, r_end, enter_addr;

  assign r_beat     = axi.rvalid && rready;
  assign r_end      = r_beat && axi.rlast;
  assign enter_addr = (nxt == ADDR) && (state != ADDR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = ADDR;
      // AR stays up until accepted even after a flush; the flush only
      // decides whether the returning burst is kept or drained.
      ADDR:  if (axi.arready) nxt = (flush || flush_pend) ? DRAIN : DATA;
      DATA: begin
        if (flush)      nxt = r_end ? ADDR : DRAIN;
        else if (r_end) nxt = HOLD;
      end
      HOLD:  if (flush || inst_ready) nxt = ADDR;
      DRAIN: if (r_end) nxt = ADDR;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    axi.arvalid = (state == ADDR);
    rready      = (state == DATA) || (state == DRAIN);
    inst_valid  = (state == HOLD);
    pc_adv      = (state == HOLD) && inst_ready && !flush;
  end

  assign axi.rready  = rready;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = SIZE_4B;
  assign axi.arburst = BURST_INCR;

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q   <= '0;
      arlen_q    <= '0;
      inst_pc    <= '0;
      inst0      <= '0;
      inst1      <= '0;
      inst1_vld  <= 1'b0;
      inst_fault <= 1'b0;
      flush_pend <= 1'b0;
      beat_idx   <= 1'b0;
    end else if (enter_addr) begin
      araddr_q   <= pc_addr;
      inst_pc    <= pc_addr;
      arlen_q    <= burst_len(pc_addr[11:2]);
      inst1_vld  <= (burst_len(pc_addr[11:2]) == 8'd1);
      inst_fault <= 1'b0;
      flush_pend <= 1'b0;
      beat_idx   <= 1'b0;
    end else begin
      if (state == ADDR && flush && !axi.arready) flush_pend <= 1'b1;
      if (state == DATA && r_beat) begin
        if (!beat_idx) inst0 <= axi.rdata;
        else           inst1 <= axi.rdata;
        beat_idx <= 1'b1;
        if (axi.rresp != RESP_OKAY) inst_fault <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ifetch_axi_master.md
IFETCH_AXI_MASTER -- requirements
Module: ifetch_axi_master

Interface
REQ-001 Parameter: ADDR_W, 32, fetch address width.
REQ-002 Parameter: DATA_W, 32, AXI read data width (one instruction per beat).
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pc_addr  input  ADDR_W  current fetch PC from the PC control stage.
REQ-006 flush  input  1  redirect (jal/jalr/branch) pulse; discards in-flight bundle.
REQ-007 araddr  output  ADDR_W  AXI read address.
REQ-008 arlen  output  8  beats-1, value 1 (2 beats) or 0 (1 beat).
REQ-009 arsize/arburst  output  3/2  fixed 3'b010 / 2'b01 (INCR).
REQ-010 arvalid / arready  output / input  1 / 1  AR handshake.
REQ-011 rdata / rresp / rlast / rvalid  input  DATA_W/2/1/1  AXI R channel.
REQ-012 rready  output  1  R channel ready.
REQ-013 inst0, inst1  output  DATA_W  bundle instructions at inst_pc and inst_pc+4.
REQ-014 inst_pc  output  ADDR_W  PC of inst0.
REQ-015 inst1_vld, inst_fault  output  1  inst1 present; any beat returned rresp!=OKAY.
REQ-016 inst_valid / inst_ready  output / input  1  bundle handshake to decode.
REQ-017 pc_adv  output  1  one-cycle pulse to PC control (its rlast input) when a bundle is accepted.

Function
REQ-018 FSM states SHALL be IDLE, ADDR, DATA, HOLD, DRAIN.
REQ-019 IDLE SHALL move to ADDR the cycle after reset deasserts.
REQ-020 On ADDR entry, pc_addr SHALL be latched into araddr and inst_pc; arvalid=1 held until arready, then DATA.
REQ-021 arlen SHALL be 0 when pc_addr[11:2]==10'h3FF (4 KB crossing), else 1; inst1_vld=(arlen==1).
REQ-022 In DATA, rready=1; beat 0 to inst0, beat 1 to inst1; rresp!=0 on any beat sets inst_fault.
REQ-023 DATA SHALL exit to HOLD on rvalid&&rlast; rlast with fewer beats than requested still ends the burst.
REQ-024 In HOLD, inst_valid=1; on inst_ready: pc_adv=1 that cycle, next state ADDR with the then-current pc_addr.
REQ-025 Bundle outputs SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-026 flush in ADDR before handshake: arvalid SHALL stay asserted with unchanged araddr until arready (AXI rule), then DRAIN.
REQ-027 flush in ADDR on the handshake cycle, or in DATA: go to DRAIN; flush in HOLD: drop bundle, no pc_adv, go to ADDR.
REQ-028 DRAIN SHALL hold rready=1, discard beats, and go to ADDR after rvalid&&rlast; inst_valid=0 throughout.
REQ-029 flush with inst_ready in HOLD: flush wins; no pc_adv.
REQ-030 inst_valid and pc_adv SHALL never assert outside HOLD; at most one outstanding AR at any time.

Reset
REQ-031 rst SHALL force state IDLE; arvalid, rready, inst_valid, pc_adv, inst1_vld, inst_fault = 0; araddr, inst_pc, inst0, inst1 = 0.
REQ-032 rst mid-burst SHALL abandon the burst without draining (interconnect is reset together).

Structure
REQ-033 FSM state enum, AXI constants (SIZE_4B, BURST_INCR, RESP_OKAY) and the 4 KB boundary mask SHALL reside in a shared package ifetch_pkg.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 pc=0x100, arready same cycle, beats 0x00000013/0x00100093 OKAY, inst_ready=1 -> inst0/inst1 match, inst_pc=0x100, inst1_vld=1, one pc_adv pulse.
REQ-036 pc=0x0FFC -> arlen=0, single beat, inst1_vld=0.
REQ-037 arready held 0 five cycles with flush in cycle 2 -> araddr stable, DRAIN consumes 2 beats, no inst_valid, next AR uses new pc.
REQ-038 beat 1 rresp=2'b10 -> inst_fault=1 in HOLD.
REQ-039 inst_ready=0 for 4 cycles in HOLD -> bundle stable, pc_adv only on the accepting cycle.
REQ-040 rst asserted during DATA -> all outputs zero next cycle, IDLE then new AR.
